uart_tx_arbiter: RTL and testbench

- Round-robin arbiter that shares the single UART transmitter (tx_asm) between NUM_REQ independent byte producers.
- Sits between the producers and the transmitter handshake (tx_valid/tx_data/tx_error/tx_parity_per_byte/tx_ready), in the transmitter's clock domain.
- Grants the transmitter per message: a grant is held until the requester's last byte, MAX_BURST bytes, or an idle timeout, then rotates.

---
 rtl/uart_tx_arbiter.sv | 148 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Purpose: round-robin share of one UART transmitter between NUM_REQ byte producers, granted per message.
// Latency: request to first tx_valid is 1 cycle from IDLE; bytes pass combinationally within a grant; 1 bubble between grants.
// Backpressure: tx_ready is routed straight to the owner's req_ready; every other requester sees req_ready=0.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int MAX_BURST    = 4,
  parameter int IDLE_TIMEOUT = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ-1:0]            req_error,
  input  logic [NUM_REQ-1:0]            req_parity_per_byte,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx_valid,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_error,
  output logic                          tx_parity_per_byte,
  input  logic                          tx_ready,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int GW = $clog2(NUM_REQ);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [GW-1:0]         last_grant;
  logic [GW-1:0]         sel;
  logic [GW-1:0]         cand;
  logic                  found;
  logic [7:0]            burst_cnt;
  logic [7:0]            idle_cnt;
  logic [DATA_WIDTH-1:0] req_bytes [NUM_REQ];
  logic                  owner_valid;
  logic                  owner_last;
  logic                  xfer;
  logic                  burst_hit;
  logic                  idle_hit;
  logic                  release_grant;

  // Unpack the flat byte bus so the owner's byte can be picked by index.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_bytes[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Round-robin search: first valid requester after last_grant, wrapping.
  always_comb begin
    sel   = last_grant;
    cand  = last_grant;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GW'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // Owner-side handshake and the three release conditions.
  assign owner_valid   = req_valid[grant_id];
  assign owner_last    = req_last[grant_id];
  assign xfer          = (state == GRANT) && owner_valid && tx_ready;
  assign burst_hit     = xfer && (burst_cnt >= 8'(MAX_BURST - 1));
  assign idle_hit      = (state == GRANT) && !owner_valid && (idle_cnt >= 8'(IDLE_TIMEOUT - 1));
  assign release_grant = (xfer && owner_last) || burst_hit || idle_hit;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: leave IDLE on any request, leave GRANT on release (a single release even if several causes coincide).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = GRANT;
      GRANT:   if (release_grant) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Owner index and priority pointer; grant_id keeps the last owner while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_id   <= '0;
      last_grant <= GW'(NUM_REQ - 1);
    end else begin
      if (state == IDLE && found) begin
        grant_id <= sel;
      end
      if (state == GRANT && release_grant) begin
        last_grant <= grant_id;
      end
    end
  end

  // Burst and idle counters: cleared outside a grant and on release, saturating at 8'hFF.
  always_ff @(posedge clk) begin
    if (rst || state == IDLE || release_grant) begin
      burst_cnt <= '0;
      idle_cnt  <= '0;
    end else begin
      if (xfer && burst_cnt != 8'hFF) begin
        burst_cnt <= burst_cnt + 8'd1;
      end
      if (owner_valid) begin
        idle_cnt <= '0;
      end else if (idle_cnt != 8'hFF) begin
        idle_cnt <= idle_cnt + 8'd1;
      end
    end
  end

  // Outputs: zero in IDLE, combinational pass-through of the owner in GRANT.
  always_comb begin
    req_ready          = '0;
    tx_valid           = 1'b0;
    tx_data            = '0;
    tx_error           = 1'b0;
    tx_parity_per_byte = 1'b0;
    busy               = 1'b0;
    if (state == GRANT) begin
      busy                = 1'b1;
      tx_valid            = owner_valid;
      tx_data             = req_bytes[grant_id];
      tx_error            = req_error[grant_id];
      tx_parity_per_byte  = req_parity_per_byte[grant_id];
      req_ready[grant_id] = tx_ready;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Purpose: directed self-checking bench for uart_tx_arbiter with hand-computed expectations.
// Latency: inputs driven 1 time unit after posedge, outputs sampled 2 units after posedge.
// Backpressure: bench producers advance their byte only after req_valid && req_ready.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_last = '0;
  logic [N-1:0]    req_error = '0;
  logic [N-1:0]    req_parity_per_byte = '0;
  logic [N-1:0]    req_ready;
  logic            tx_valid;
  logic [DW-1:0]   tx_data;
  logic            tx_error;
  logic            tx_parity_per_byte;
  logic            tx_ready = 1'b0;
  logic [1:0]      grant_id;
  logic            busy;

  int n_vec = 0;
  int n_err = 0;

  // Per-requester producer model: byte = base + index, last when index == last_idx.
  logic [7:0]   base [N];
  logic [7:0]   pk [N];
  logic [7:0]   last_idx [N];
  logic [N-1:0] err_f = '0;
  logic [N-1:0] par_f = '0;
  logic [N-1:0] hs = '0;

  logic       rdy_seq [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [7:0] dat_seq [6] = '{8'h50, 8'h51, 8'h51, 8'h51, 8'h52, 8'h53};

  uart_tx_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(4), .IDLE_TIMEOUT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_error(req_error),
    .req_parity_per_byte(req_parity_per_byte),
    .req_ready(req_ready),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_error(tx_error),
    .tx_parity_per_byte(tx_parity_per_byte),
    .tx_ready(tx_ready),
    .grant_id(grant_id),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fields();
    for (int i = 0; i < N; i++) begin
      req_data[i*DW +: DW]   = base[i] + pk[i];
      req_last[i]            = (pk[i] == last_idx[i]);
      req_error[i]           = err_f[i];
      req_parity_per_byte[i] = par_f[i];
    end
  endtask

  // One cycle: advance producers on last cycle's handshakes, apply new inputs, settle.
  task automatic step(input logic [N-1:0] v, input logic rdy);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) pk[i] = pk[i] + 8'd1;
    end
    req_valid = v;
    tx_ready  = rdy;
    drive_fields();
    #1;
    hs = req_valid & req_ready;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    tx_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < N; i++) pk[i] = 8'd0;
    hs = '0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      base[i]     = 8'h00;
      pk[i]       = 8'h00;
      last_idx[i] = 8'hFF;
    end

    // Reset state
    do_reset();
    chk("rst_busy", busy, 1'b0);
    chk("rst_txv", tx_valid, 1'b0);
    chk("rst_txd", tx_data, 8'h00);
    chk("rst_err", tx_error, 1'b0);
    chk("rst_par", tx_parity_per_byte, 1'b0);
    chk("rst_rdy", req_ready, 4'b0000);
    chk("rst_gid", grant_id, 2'd0);

    // 3-byte message from requester 0
    base[0] = 8'hA1; last_idx[0] = 8'd2;
    step(4'b0001, 1'b1);
    chk("t1_idle_busy", busy, 1'b0);
    chk("t1_idle_txv", tx_valid, 1'b0);
    for (int b = 0; b < 3; b++) begin
      step(4'b0001, 1'b1);
      chk("t1_busy", busy, 1'b1);
      chk("t1_txv", tx_valid, 1'b1);
      chk("t1_data", tx_data, 8'hA1 + b);
      chk("t1_rdy", req_ready, 4'b0001);
    end
    step(4'b0000, 1'b1);
    chk("t1_end_busy", busy, 1'b0);
    chk("t1_end_gid", grant_id, 2'd0);
    chk("t1_end_txv", tx_valid, 1'b0);

    // All four requesters streaming, burst-limited rotation 0,1,2,3,0
    do_reset();
    for (int i = 0; i < N; i++) begin
      base[i]     = 8'h80 + 8'(i * 16);
      last_idx[i] = 8'hFF;
    end
    step(4'b1111, 1'b1);
    chk("t2_idle_busy", busy, 1'b0);
    for (int g = 0; g < 5; g++) begin
      for (int b = 0; b < 4; b++) begin
        step(4'b1111, 1'b1);
        chk("t2_busy", busy, 1'b1);
        chk("t2_gid", grant_id, g % 4);
        chk("t2_rdy", req_ready, 1 << (g % 4));
        chk("t2_data", tx_data, 32'h80 + (g % 4) * 16 + (g / 4) * 4 + b);
      end
      step(4'b1111, 1'b1);
      chk("t2_bubble_busy", busy, 1'b0);
      chk("t2_bubble_txv", tx_valid, 1'b0);
    end

    // Idle timeout on requester 2, then rotation to requester 3
    do_reset();
    base[2] = 8'hC0; base[3] = 8'hD0; base[0] = 8'h10;
    step(4'b0100, 1'b1);
    chk("t3_idle_busy", busy, 1'b0);
    step(4'b0100, 1'b1);
    chk("t3_gid", grant_id, 2'd2);
    chk("t3_data", tx_data, 8'hC0);
    for (int c = 1; c <= 8; c++) begin
      step(4'b1001, 1'b1);
      chk("t3_hold_busy", busy, 1'b1);
      chk("t3_hold_txv", tx_valid, 1'b0);
      chk("t3_hold_gid", grant_id, 2'd2);
    end
    step(4'b1001, 1'b1);
    chk("t3_rel_busy", busy, 1'b0);
    chk("t3_rel_gid", grant_id, 2'd2);
    step(4'b1001, 1'b1);
    chk("t3_next_busy", busy, 1'b1);
    chk("t3_next_gid", grant_id, 2'd3);
    chk("t3_next_data", tx_data, 8'hD0);

    // tx_ready stalls mid-grant: bytes held stable, burst counts only transfers
    do_reset();
    base[0] = 8'h50; last_idx[0] = 8'hFF;
    step(4'b0001, 1'b1);
    chk("t4_idle_busy", busy, 1'b0);
    for (int c = 0; c < 6; c++) begin
      step(4'b0001, rdy_seq[c]);
      chk("t4_busy", busy, 1'b1);
      chk("t4_txv", tx_valid, 1'b1);
      chk("t4_data", tx_data, dat_seq[c]);
      chk("t4_rdy", req_ready, rdy_seq[c] ? 4'b0001 : 4'b0000);
    end
    step(4'b0000, 1'b1);
    chk("t4_end_busy", busy, 1'b0);

    // Reset mid-grant after 2 bytes, then requester 0 wins first
    base[2] = 8'h70; pk[2] = 8'd0;
    step(4'b0100, 1'b1);
    chk("t5_idle_busy", busy, 1'b0);
    step(4'b0100, 1'b1);
    chk("t5_gid", grant_id, 2'd2);
    chk("t5_data0", tx_data, 8'h70);
    step(4'b0100, 1'b1);
    chk("t5_data1", tx_data, 8'h71);
    rst = 1'b1;
    step(4'b0101, 1'b1);
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_txv", tx_valid, 1'b0);
    chk("t5_rst_txd", tx_data, 8'h00);
    chk("t5_rst_err", tx_error, 1'b0);
    chk("t5_rst_par", tx_parity_per_byte, 1'b0);
    chk("t5_rst_rdy", req_ready, 4'b0000);
    chk("t5_rst_gid", grant_id, 2'd0);
    rst = 1'b0;
    base[0] = 8'h30; pk[0] = 8'd0;
    step(4'b0101, 1'b1);
    chk("t5_after_busy", busy, 1'b1);
    chk("t5_after_gid", grant_id, 2'd0);
    chk("t5_after_data", tx_data, 8'h30);

    // Error and parity flags travel with requester 1's byte
    do_reset();
    base[1] = 8'h5A; last_idx[1] = 8'd0;
    base[3] = 8'hD0; last_idx[3] = 8'hFF;
    err_f = 4'b0010; par_f = 4'b0010;
    step(4'b1010, 1'b1);
    chk("t6_idle_busy", busy, 1'b0);
    chk("t6_idle_err", tx_error, 1'b0);
    step(4'b1010, 1'b1);
    chk("t6_gid", grant_id, 2'd1);
    chk("t6_data", tx_data, 8'h5A);
    chk("t6_err", tx_error, 1'b1);
    chk("t6_par", tx_parity_per_byte, 1'b1);
    chk("t6_rdy", req_ready, 4'b0010);
    step(4'b1010, 1'b1);
    chk("t6_bubble_busy", busy, 1'b0);
    step(4'b1010, 1'b1);
    chk("t6_next_gid", grant_id, 2'd3);
    chk("t6_next_data", tx_data, 8'hD0);
    chk("t6_next_err", tx_error, 1'b0);
    chk("t6_next_par", tx_parity_per_byte, 1'b0);
    chk("t6_next_rdy", req_ready, 4'b1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
